// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 codes for the RV32 load/store sizes
//   - lsu_state_t: access sequencing states
//   - size_bytes(): byte count of an access from its funct3 code
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Access size in bytes; illegal codes report 4 (they never reach memory).
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_bytes = 3'd1;
      F3_H, F3_HU: size_bytes = 3'd2;
      default:     size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit (purely combinational).
//   off, funct3  : byte offset within the word and access code
//   wdata        : right-justified store data
//   buf0, buf1   : load words read in the first / second access
//   mask8        : byte-enable across the two-word window
//   wdata64      : store data shifted into its lanes, unused lanes zero
//   rdata        : realigned, sign/zero-extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   buf0,
  input  logic [XLEN-1:0]   buf1,
  output logic [7:0]        mask8,
  output logic [2*XLEN-1:0] wdata64,
  output logic [XLEN-1:0]   rdata
);

  logic [3:0]        base_mask;
  logic [XLEN-1:0]   wdata_trim;
  logic [2*XLEN-1:0] rd_shift;

  // Store side: trim data to the access size, then shift into lanes.
  always_comb begin
    base_mask  = 4'b1111;
    wdata_trim = wdata;
    case (size_bytes(funct3))
      3'd1: begin
        base_mask  = 4'b0001;
        wdata_trim = {24'h0, wdata[7:0]};
      end
      3'd2: begin
        base_mask  = 4'b0011;
        wdata_trim = {16'h0, wdata[15:0]};
      end
      default: ;
    endcase
    mask8   = 8'({4'b0000, base_mask}) << off;
    wdata64 = {32'h0, wdata_trim} << {off, 3'b000};
  end

  // Load side: shift the two-word window down by the offset, then extend.
  always_comb begin
    rd_shift = {buf1, buf0} >> {off, 3'b000};
    case (funct3)
      F3_B:    rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
      F3_H:    rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
      F3_BU:   rdata = {24'h0, rd_shift[7:0]};
      F3_HU:   rdata = {16'h0, rd_shift[15:0]};
      default: rdata = rd_shift[31:0];
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: initiator side of the data-memory port.
//   clk, rst        : clock, asynchronous active-low reset
//   req_*           : core request (store flag, funct3, byte address, data)
//   resp_*          : one-cycle completion pulse with load data / error
//   mem_*           : word-addressed dmem port with byte write mask
// Misaligned accesses are split into two consecutive word accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_data_in,
  output logic [3:0]      mem_wmask,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_data_out
);

  lsu_state_t      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] buf0_q, buf0_d;
  logic [XLEN-1:0] buf1_q, buf1_d;
  logic            ready_q, ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;

  logic [2:0]        req_size;
  logic              req_split;
  logic [30:0]       req_last_word;
  logic              req_f3_bad;
  logic              req_illegal;
  logic              cur_split;
  logic [7:0]        mask8;
  logic [2*XLEN-1:0] wdata64;
  logic [XLEN-1:0]   ld_data;

  lsu_align u_align (
    .off     (addr_q[1:0]),
    .funct3  (funct3_q),
    .wdata   (wdata_q),
    .buf0    (buf0_q),
    .buf1    (buf1_q),
    .mask8   (mask8),
    .wdata64 (wdata64),
    .rdata   (ld_data)
  );

  // Request legality: funct3 must suit the direction, every touched word in range.
  always_comb begin
    req_size      = size_bytes(req_funct3);
    req_split     = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
    req_last_word = {1'b0, req_addr[31:2]} + 31'(req_split);
    if (req_we) begin
      req_f3_bad = !(req_funct3 inside {F3_B, F3_H, F3_W});
    end else begin
      req_f3_bad = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    req_illegal = req_f3_bad || (req_last_word >= 31'(MEM_SIZE));
  end

  assign cur_split = ({1'b0, addr_q[1:0]} + size_bytes(funct3_q)) > 3'd4;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    case (state_q)
      IDLE: begin
        if (ready_q && req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_illegal;
          buf0_d   = '0;
          buf1_d   = '0;
          state_d  = req_illegal ? DONE : ACC0;
        end
      end
      ACC0: begin
        if (!we_q) buf0_d = mem_data_out;
        state_d = cur_split ? ACC1 : DONE;
      end
      ACC1: begin
        if (!we_q) buf1_d = mem_data_out;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d      = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
    resp_err_d   = (state_d == DONE) && err_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Memory port decoded from registered state only; quiet outside accesses.
  always_comb begin
    mem_addr    = '0;
    mem_data_in = '0;
    mem_wmask   = 4'b0000;
    mem_we      = 1'b0;
    case (state_q)
      ACC0: begin
        mem_addr = {2'b00, addr_q[31:2]};
        if (we_q) begin
          mem_we      = 1'b1;
          mem_wmask   = mask8[3:0];
          mem_data_in = wdata64[31:0];
        end
      end
      ACC1: begin
        mem_addr = {2'b00, addr_q[31:2]} + 32'd1;
        if (we_q) begin
          mem_we      = 1'b1;
          mem_wmask   = mask8[7:4];
          mem_data_in = wdata64[63:32];
        end
      end
      default: ;
    endcase
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = (state_q == DONE && !we_q && !err_q) ? ld_data : '0;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  import lsu_pkg::*;

  localparam int unsigned MEM_SIZE = 1024;
  localparam int unsigned NBYTES   = 4 * MEM_SIZE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_wmask;
  logic        mem_we;
  logic [31:0] mem_data_out;

  lsu #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wmask(mem_wmask),
    .mem_we(mem_we), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Attached data memory: asynchronous read, byte-masked synchronous write.
  logic [31:0] dmem [MEM_SIZE] = '{default: 32'h0};
  assign mem_data_out = (mem_addr < MEM_SIZE) ? dmem[mem_addr[9:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_we && mem_addr < MEM_SIZE)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) dmem[mem_addr[9:0]][8*b +: 8] <= mem_data_in[8*b +: 8];
  end

  // Reference model: flat byte-addressed memory.
  logic [7:0] ref_mem [NBYTES] = '{default: 8'h0};

  int checks = 0;
  int errors = 0;

  logic [31:0] acc_addr [4];
  logic [31:0] acc_data [4];
  logic [3:0]  acc_mask [4];
  logic        acc_we   [4];
  logic        any_we;

  logic [31:0] dut_rdata, ref_rdata;
  logic        dut_err, ref_err;
  int          dut_lat, ref_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rd,
                            output logic er, output int lt);
    int sz;
    longint unsigned last;
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    er = we ? (f3 > 3'b010) : (sz == 0);
    if (!er) begin
      last = longint'(addr) + longint'(sz) - 1;
      if (longint'(addr) / 4 >= MEM_SIZE || last / 4 >= MEM_SIZE) er = 1'b1;
    end
    rd = 32'h0;
    lt = 1;
    if (!er) begin
      lt = ((addr % 4) + sz > 4) ? 3 : 2;
      if (we) begin
        for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
        if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
        rd = v;
      end
    end
  endtask

  task automatic wait_ready();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      errors++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
    end
  endtask

  // Issue one request at a negedge and sample every cycle up to the response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    logic got;
    wait_ready();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0; any_we = 1'b0; dut_rdata = 32'h0; dut_err = 1'b0; dut_lat = 99;
    for (int k = 0; k < 4; k++) begin
      acc_addr[k] = 32'h0; acc_data[k] = 32'h0; acc_mask[k] = 4'h0; acc_we[k] = 1'b0;
    end
    for (int k = 0; k < 8 && !got; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 4) begin
        acc_addr[k] = mem_addr; acc_data[k] = mem_data_in;
        acc_mask[k] = mem_wmask; acc_we[k] = mem_we;
      end
      if (mem_we) any_we = 1'b1;
      if (resp_valid) begin
        got = 1'b1; dut_lat = k + 1; dut_rdata = resp_rdata; dut_err = resp_err;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 8 cycles");
    end
  endtask

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata);
    ref_access(we, f3, addr, wdata, ref_rdata, ref_err, ref_lat);
    do_req(we, f3, addr, wdata);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl [23];
  int   mism;
  logic [31:0] w;

  initial begin
    tbl[0]  = '{1'b0, F3_B,   32'h13,  32'h0,        32'hFFFFFFAB, 1'b0, 2};
    tbl[1]  = '{1'b0, F3_BU,  32'h13,  32'h0,        32'h000000AB, 1'b0, 2};
    tbl[2]  = '{1'b0, F3_W,   32'h0E,  32'h0,        32'h11223344, 1'b0, 3};
    tbl[3]  = '{1'b0, F3_W,   32'h10,  32'h0,        32'hABAD1122, 1'b0, 2};
    tbl[4]  = '{1'b1, F3_W,   32'h04,  32'h80000000, 32'h0,        1'b0, 2};
    tbl[5]  = '{1'b1, F3_W,   32'h08,  32'h00000012, 32'h0,        1'b0, 2};
    tbl[6]  = '{1'b0, F3_H,   32'h07,  32'h0,        32'h00001280, 1'b0, 3};
    tbl[7]  = '{1'b1, F3_B,   32'h08,  32'h00000092, 32'h0,        1'b0, 2};
    tbl[8]  = '{1'b0, F3_H,   32'h07,  32'h0,        32'hFFFF9280, 1'b0, 3};
    tbl[9]  = '{1'b0, F3_HU,  32'h07,  32'h0,        32'h00009280, 1'b0, 3};
    tbl[10] = '{1'b0, 3'b011, 32'h00,  32'h0,        32'h0,        1'b1, 1};
    tbl[11] = '{1'b1, F3_W,   32'hFFE, 32'h55667788, 32'h0,        1'b1, 1};
    tbl[12] = '{1'b1, F3_BU,  32'h20,  32'h12345678, 32'h0,        1'b1, 1};
    tbl[13] = '{1'b0, F3_B,   32'hFFF, 32'h0,        32'h0,        1'b0, 2};
    tbl[14] = '{1'b0, F3_W,   32'h1000,32'h0,        32'h0,        1'b1, 1};
    tbl[15] = '{1'b0, 3'b110, 32'h20,  32'h0,        32'h0,        1'b1, 1};
    tbl[16] = '{1'b0, F3_H,   32'hFFE, 32'h0,        32'h0,        1'b0, 2};
    tbl[17] = '{1'b0, F3_H,   32'hFFF, 32'h0,        32'h0,        1'b1, 1};
    tbl[18] = '{1'b1, F3_H,   32'h21,  32'hFFFFBEEF, 32'h0,        1'b0, 2};
    tbl[19] = '{1'b0, F3_W,   32'h20,  32'h0,        32'h00BEEF00, 1'b0, 2};
    tbl[20] = '{1'b1, F3_H,   32'h23,  32'h0000CAFE, 32'h0,        1'b0, 3};
    tbl[21] = '{1'b0, F3_HU,  32'h23,  32'h0,        32'h0000CAFE, 1'b0, 3};
    tbl[22] = '{1'b0, F3_W,   32'h24,  32'h0,        32'h000000CA, 1'b0, 2};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_data_in", mem_data_in, 32'h0);
    rst = 1'b1;

    // Aligned SW: lanes of the single access, then quiet DONE.
    run(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    chk("sw_acc0_addr", acc_addr[0], 32'd4);
    chk("sw_acc0_mask", 32'(acc_mask[0]), 32'hF);
    chk("sw_acc0_data", acc_data[0], 32'hDEADBEEF);
    chk("sw_acc0_we", 32'(acc_we[0]), 32'h1);
    chk("sw_done_we", 32'(acc_we[1]), 32'h0);
    chk("sw_lat", 32'(dut_lat), 32'd2);
    chk("sw_err", 32'(dut_err), 32'h0);

    // SB at the top byte lane.
    run(1'b1, F3_B, 32'h13, 32'h000000AB);
    chk("sb_mask", 32'(acc_mask[0]), 32'h8);
    chk("sb_data", acc_data[0], 32'hAB000000);

    // Misaligned SW split over words 3 and 4.
    run(1'b1, F3_W, 32'h0E, 32'h11223344);
    chk("msw_acc0_addr", acc_addr[0], 32'd3);
    chk("msw_acc0_mask", 32'(acc_mask[0]), 32'hC);
    chk("msw_acc0_data", acc_data[0], 32'h33440000);
    chk("msw_acc1_addr", acc_addr[1], 32'd4);
    chk("msw_acc1_mask", 32'(acc_mask[1]), 32'h3);
    chk("msw_acc1_data", acc_data[1], 32'h00001122);
    chk("msw_acc1_we", 32'(acc_we[1]), 32'h1);
    chk("msw_done_mask", 32'(acc_mask[2]), 32'h0);
    chk("msw_lat", 32'(dut_lat), 32'd3);

    // Directed vector table.
    for (int i = 0; i < 23; i++) begin
      run(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("vec%0d_rdata", i), dut_rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(dut_err), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(dut_lat), 32'(tbl[i].exp_lat));
      if (tbl[i].exp_err) chk($sformatf("vec%0d_no_write", i), 32'(any_we), 32'h0);
    end

    // Reset during ACC1 of a split load.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h0E; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_acc0_addr", mem_addr, 32'd3);
    @(posedge clk);
    #1;
    chk("rstmid_acc1_addr", mem_addr, 32'd4);
    #1 rst = 1'b0;
    #1;
    chk("rstmid_async_addr", mem_addr, 32'h0);
    chk("rstmid_async_valid", 32'(resp_valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rstmid_ready%0d", k), 32'(req_ready), 32'h0);
      chk($sformatf("rstmid_valid%0d", k), 32'(resp_valid), 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstrel_ready", 32'(req_ready), 32'h1);
    chk("rstrel_valid", 32'(resp_valid), 32'h0);
    run(1'b0, F3_W, 32'h10, 32'h0);
    chk("rstrel_lw_rdata", dut_rdata, ref_rdata);
    chk("rstrel_lw_lat", 32'(dut_lat), 32'd2);

    // Randomized traffic against the byte-level model.
    for (int i = 0; i < 150; i++) begin
      logic        rwe;
      logic [2:0]  rf3;
      logic [31:0] raddr;
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) raddr = 32'(NBYTES - 8 + $urandom_range(0, 15));
      else raddr = 32'($urandom_range(0, 255));
      run(rwe, rf3, raddr, $urandom);
      chk($sformatf("rnd%0d_rdata", i), dut_rdata, ref_rdata);
      chk($sformatf("rnd%0d_err", i), 32'(dut_err), 32'(ref_err));
      chk($sformatf("rnd%0d_lat", i), 32'(dut_lat), 32'(ref_lat));
      if (ref_err) chk($sformatf("rnd%0d_no_write", i), 32'(any_we), 32'h0);
    end

    // Whole-memory comparison against the model.
    @(negedge clk);
    mism = 0;
    for (int a = 0; a < int'(MEM_SIZE); a++) begin
      w = {ref_mem[4*a+3], ref_mem[4*a+2], ref_mem[4*a+1], ref_mem[4*a]};
      if (dmem[a] !== w) mism++;
    end
    chk("mem_final_mismatch_words", 32'(mism), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
